// File: rtl/vga_text_console_if.sv
// Character stream in, character-RAM write port out.
// The console itself sits on the slave side.
interface vga_text_console_if;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [31:0] waddr;
    logic [7:0]  wdata;
    logic        selRW;

    modport master (
        output char_valid, char_data,
        input  char_ready, waddr, wdata, selRW
    );

    modport slave (
        input  char_valid, char_data,
        output char_ready, waddr, wdata, selRW
    );
endinterface

// File: rtl/vga_text_console.sv
// Text console cursor engine feeding the VGA character RAM.
// Decodes a byte stream into per-cell writes, wraps and clears.
module vga_text_console #(
    parameter int          COLS           = 80,
    parameter int          ROWS           = 32,
    parameter int          COL_BITS       = 7,
    parameter int          ROW_BITS       = 5,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          WR_HOLD        = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    vga_text_console_if.slave   bus,
    output logic                busy,
    output logic [ROW_BITS-1:0] cur_row,
    output logic [COL_BITS-1:0] cur_col
);

    typedef enum logic [1:0] {
        IDLE, WRITE, CLR_LINE, CLR_ALL
    } state_t;

    localparam logic [COL_BITS-1:0] COL_MAX  = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_MAX  = ROW_BITS'(ROWS - 1);
    localparam logic [3:0]          HOLD_MAX = 4'(WR_HOLD - 1);
    localparam logic [7:0]          SPACE    = 8'h20;

    state_t              state_q, state_d;
    logic [ROW_BITS-1:0] row_q, row_d, sr_q, sr_d;
    logic [COL_BITS-1:0] col_q, col_d, sc_q, sc_d;
    logic [3:0]          hold_q, hold_d;
    logic [31:0]         waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                sel_q, sel_d;
    logic                rdy_q, busy_q, bs_q, bs_d;
    logic                accept, printable, clr_last;

    function automatic logic [31:0] cell_addr(
        input logic [ROW_BITS-1:0] r,
        input logic [COL_BITS-1:0] c
    );
        return BASE_ADDR + (32'(r) << COL_BITS) + 32'(c);
    endfunction

    assign accept    = bus.char_valid && rdy_q;
    assign printable = bus.char_data >= 8'h20 && bus.char_data <= 8'h7E;
    assign clr_last  = sc_q == COL_MAX &&
                       (state_q == CLR_LINE || sr_q == ROW_MAX);

    // Next-state, cursor and write-port decode.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sr_d    = sr_q;
        sc_d    = sc_q;
        hold_d  = hold_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        bs_d    = bs_q;
        unique case (state_q)
            IDLE: begin
                sel_d = 1'b0;
                if (accept) begin
                    unique case (1'b1)
                        printable: begin
                            state_d = WRITE;
                            waddr_d = cell_addr(row_q, col_q);
                            wdata_d = bus.char_data;
                            sel_d   = 1'b1;
                            hold_d  = '0;
                            bs_d    = 1'b0;
                        end
                        bus.char_data == 8'h0A: begin
                            col_d = '0;
                            if (row_q != ROW_MAX) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                row_d   = '0;
                                state_d = CLR_LINE;
                                sr_d    = '0;
                                sc_d    = '0;
                                waddr_d = cell_addr('0, '0);
                                wdata_d = SPACE;
                                sel_d   = 1'b1;
                                hold_d  = '0;
                            end
                        end
                        bus.char_data == 8'h0D: begin
                            col_d = '0;
                        end
                        bus.char_data == 8'h08: begin
                            if (col_q != '0) begin
                                col_d   = col_q - 1'b1;
                                state_d = WRITE;
                                waddr_d = cell_addr(row_q, col_q - 1'b1);
                                wdata_d = SPACE;
                                sel_d   = 1'b1;
                                hold_d  = '0;
                                bs_d    = 1'b1;
                            end
                        end
                        bus.char_data == 8'h0C: begin
                            state_d = CLR_ALL;
                            sr_d    = '0;
                            sc_d    = '0;
                            waddr_d = cell_addr('0, '0);
                            wdata_d = SPACE;
                            sel_d   = 1'b1;
                            hold_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            WRITE: begin
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d  = '0;
                    sel_d   = 1'b0;
                    state_d = IDLE;
                    if (!bs_q) begin
                        if (col_q != COL_MAX) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (row_q != ROW_MAX) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                row_d   = '0;
                                state_d = CLR_LINE;
                                sr_d    = '0;
                                sc_d    = '0;
                                waddr_d = cell_addr('0, '0);
                                wdata_d = SPACE;
                                sel_d   = 1'b1;
                            end
                        end
                    end
                end
            end
            CLR_LINE, CLR_ALL: begin
                wdata_d = SPACE;
                if (!sel_q) begin
                    sel_d   = 1'b1;
                    hold_d  = '0;
                    waddr_d = cell_addr(sr_q, sc_q);
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end else begin
                    hold_d = '0;
                    if (clr_last) begin
                        sel_d   = 1'b0;
                        state_d = IDLE;
                        if (state_q == CLR_ALL) begin
                            row_d = '0;
                            col_d = '0;
                        end
                    end else begin
                        if (sc_q == COL_MAX) begin
                            sc_d = '0;
                            sr_d = sr_q + 1'b1;
                        end else begin
                            sc_d = sc_q + 1'b1;
                        end
                        waddr_d = cell_addr(sr_d, sc_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
            row_q   <= '0;
            col_q   <= '0;
            sr_q    <= '0;
            sc_q    <= '0;
            hold_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            bs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sr_q    <= sr_d;
            sc_q    <= sc_d;
            hold_q  <= hold_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            rdy_q   <= state_d == IDLE;
            busy_q  <= state_d != IDLE;
            bs_q    <= bs_d;
        end
    end

    assign bus.char_ready = rdy_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.selRW      = sel_q;
    assign busy           = busy_q;
    assign cur_row        = row_q;
    assign cur_col        = col_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: queued expected writes checked
// by a write-port monitor, plus directed cursor/timing checks.
module tb_vga_text_console;

    localparam int WR_HOLD = 2;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    logic       busy, b_busy;
    logic [4:0] row, b_row;
    logic [6:0] col, b_col;

    int   nvec = 0;
    int   nerr = 0;
    int   hcnt = 0;
    exp_t exp_q[$];
    logic [31:0] cur_a;
    logic [7:0]  cur_d;

    vga_text_console_if a ();
    vga_text_console_if b ();

    vga_text_console #(
        .WR_HOLD(WR_HOLD),
        .CLEAR_ON_RESET(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(a),
        .busy(busy),
        .cur_row(row),
        .cur_col(col)
    );

    vga_text_console #(
        .WR_HOLD(WR_HOLD),
        .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk),
        .rst(rst1),
        .bus(b),
        .busy(b_busy),
        .cur_row(b_row),
        .cur_col(b_col)
    );

    always #5 clk = ~clk;

    // Monitor: one queued expectation per WR_HOLD-cycle strobe window.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hcnt = 0;
        end else if (a.selRW) begin
            if (hcnt == 0) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_write addr=%0d data=%h",
                             a.waddr, a.wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (a.waddr !== e.a || a.wdata !== e.d) begin
                        nerr++;
                        $display("FAIL write: got %0d/%h expected %0d/%h",
                                 a.waddr, a.wdata, e.a, e.d);
                    end
                end
                cur_a = a.waddr;
                cur_d = a.wdata;
            end else begin
                nvec++;
                if (a.waddr !== cur_a || a.wdata !== cur_d) begin
                    nerr++;
                    $display("FAIL hold_stable: got %0d/%h expected %0d/%h",
                             a.waddr, a.wdata, cur_a, cur_d);
                end
            end
            hcnt = (hcnt + 1) % WR_HOLD;
        end else begin
            if (hcnt != 0) begin
                nvec++;
                nerr++;
                $display("FAIL strobe_len: got %0d expected %0d",
                         hcnt, WR_HOLD);
            end
            hcnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int ad, input logic [7:0] d);
        exp_t e;
        e.a = 32'(ad);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        a.char_valid = 1'b1;
        a.char_data  = c;
        while (!a.char_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (!a.char_ready) begin
            nvec++;
            nerr++;
            $display("FAIL send_timeout: got 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        a.char_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!a.char_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(a.char_ready), 32'd1);
    endtask

    task automatic put(input logic [7:0] c, input int ad);
        push(ad, c);
        send(c);
    endtask

    task automatic cursor(input string nm, input int r, input int c);
        wait_ready();
        chk({nm, "_row"}, 32'(row), 32'(r));
        chk({nm, "_col"}, 32'(col), 32'(c));
    endtask

    initial begin
        int n;
        int bz;
        a.char_valid = 1'b0;
        a.char_data  = 8'h00;
        b.char_valid = 1'b0;
        b.char_data  = 8'h00;
        rst  = 1'b1;
        rst1 = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_waddr", a.waddr, 32'd0);
        chk("rst_wdata", 32'(a.wdata), 32'd0);
        chk("rst_sel", 32'(a.selRW), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(a.char_ready), 32'd0);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_col", 32'(col), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 'A' at (0,0), char_ready back 3 cycles after accept.
        put(8'h41, 0);
        chk("a_sel", 32'(a.selRW), 32'd1);
        n = 1;
        while (!a.char_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_ready_lat", 32'(n), 32'(WR_HOLD + 1));
        cursor("a", 0, 1);

        // Full row then 'B' lands on row 1.
        send(8'h0D);
        for (int i = 0; i < 80; i++) put(8'h61 + 8'(i % 26), i);
        cursor("row_wrap", 1, 0);
        put(8'h42, 128);
        cursor("b", 1, 1);

        // Walk to (31,5), LF wraps and clears row 0.
        send(8'h0D);
        repeat (30) send(8'h0A);
        for (int i = 0; i < 5; i++) put(8'h30 + 8'(i), 3968 + i);
        cursor("r31", 31, 5);
        for (int i = 0; i < 80; i++) push(i, 8'h20);
        send(8'h0A);
        n = 0;
        bz = 0;
        while (a.selRW && n < 400) begin
            if (!busy) bz++;
            n++;
            @(negedge clk);
        end
        chk("lf_clr_cycles", 32'(n), 32'd160);
        chk("lf_clr_busy_low", 32'(bz), 32'd0);
        cursor("lf_wrap", 0, 0);

        // Backspace at col 0 does nothing; at (3,7) blanks col 6.
        send(8'h08);
        repeat (4) @(negedge clk);
        chk("bs0_sel", 32'(a.selRW), 32'd0);
        cursor("bs0", 0, 0);
        repeat (3) send(8'h0A);
        for (int i = 0; i < 7; i++) put(8'h41 + 8'(i), 384 + i);
        cursor("r3", 3, 7);
        push(390, 8'h20);
        send(8'h08);
        cursor("bs", 3, 6);

        // Form feed from (10,10) clears the whole screen.
        repeat (7) send(8'h0A);
        for (int i = 0; i < 10; i++) put(8'h7E, 1280 + i);
        cursor("r10", 10, 10);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 80; c++) push(r * 128 + c, 8'h20);
        send(8'h0C);
        n = 0;
        while (!a.char_ready && n < 6000) begin
            n++;
            @(negedge clk);
        end
        chk("ff_busy_cycles", 32'(n), 32'd5120);
        cursor("ff", 0, 0);
        chk("ff_pending", 32'(exp_q.size()), 32'd0);

        // BEL is swallowed without a write.
        send(8'h07);
        repeat (4) @(negedge clk);
        chk("bel_ready", 32'(a.char_ready), 32'd1);
        chk("bel_pending", 32'(exp_q.size()), 32'd0);
        cursor("bel", 0, 0);

        // Reset in the middle of a full clear.
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 80; c++) push(r * 128 + c, 8'h20);
        send(8'h0C);
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_sel", 32'(a.selRW), 32'd0);
        chk("mid_waddr", a.waddr, 32'd0);
        chk("mid_wdata", 32'(a.wdata), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(a.char_ready), 32'd0);
        chk("mid_row", 32'(row), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cursor("mid_rel", 0, 0);
        repeat (4) @(negedge clk);

        // Auto clear after reset release.
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        chk("cor_sel", 32'(b.selRW), 32'd1);
        chk("cor_waddr", b.waddr, 32'd0);
        chk("cor_wdata", 32'(b.wdata), 32'h20);
        chk("cor_ready", 32'(b.char_ready), 32'd0);
        chk("cor_busy", 32'(b_busy), 32'd1);
        repeat (20) @(negedge clk);
        chk("cor_waddr21", b.waddr, 32'd10);
        #2 rst1 = 1'b0;
        #1;
        chk("cor_rst_sel", 32'(b.selRW), 32'd0);
        chk("cor_rst_waddr", b.waddr, 32'd0);
        chk("cor_rst_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        rst1 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("cor2_sel", 32'(b.selRW), 32'd1);
                chk("cor2_waddr", b.waddr, 32'd0);
            end
        end while (!b.char_ready && n < 6000);
        chk("cor2_cycles", 32'(n), 32'd5121);
        chk("cor2_row", 32'(b_row), 32'd0);
        chk("cor2_col", 32'(b_col), 32'd0);

        chk("end_pending", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Upstream feeder for the VGA text controller's write side.
- Accepts a byte-stream of characters from the CPU bus/IO register and keeps a hardware cursor over an 80x32 character grid (1280x1024 at 16x32 pixel cells).
- Emits per-cell write commands (waddr/wdata/selRW) into the character RAM.
- Handles control characters, line wrap, and line clear on vertical wrap. Form feed triggers a full-screen clear.

Parameters:
- COLS, 80, visible columns per row.
- ROWS, 32, visible rows.
- COL_BITS, 7, column field width; row stride in waddr is 2^COL_BITS.
- ROW_BITS, 5, row field width.
- BASE_ADDR, 32'h0, value added to every emitted waddr.
- WR_HOLD, 2, cycles selRW/waddr/wdata are held per cell write (1..15).
- CLEAR_ON_RESET, 1, when 1 a full clear runs automatically after reset release.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-low reset.
- char_valid, input, 1, char_data is valid this cycle.
- char_data, input, 8, ASCII character.
- char_ready, output, 1, block can accept a character; transfer occurs when char_valid & char_ready.
- waddr, output, 32, cell address = BASE_ADDR + (row << COL_BITS) + col.
- wdata, output, 8, ASCII code to write.
- selRW, output, 1, write strobe to the character RAM, high during a write.
- busy, output, 1, high in any state other than IDLE.
- cur_row, output, ROW_BITS, current cursor row.
- cur_col, output, COL_BITS, current cursor column.

Behaviour:
- Reset (rst=0, async)
  - waddr=0, wdata=0, selRW=0, busy=0, char_ready=0, cursor=(0,0), hold counter=0.
  - State goes to IDLE, or to CLR_ALL when CLEAR_ON_RESET=1.
  - Reset mid-operation aborts immediately with no partial strobe, and the cursor returns to (0,0).
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- IDLE
  - char_ready=1 and selRW=0.
  - A transfer at edge N is decoded as listed below.
- Character decode on transfer:
  - 0x20..0x7E: go to WRITE. waddr/wdata are the cursor cell and char from cycle N+1.
  - 0x0A (LF): col=0. If row<ROWS-1 then row+1. Otherwise row=0 and go to CLR_LINE for row 0. No write for the LF itself.
  - 0x0D (CR): col=0, no write, stay in IDLE.
  - 0x08 (BS): if col>0, col-1 then WRITE 0x20 at the new position. If col=0, no action.
  - 0x0C (FF): go to CLR_ALL and set the cursor to (0,0) on completion.
  - Any other code is consumed silently (char_ready stays 1, no write).
- WRITE
  - selRW=1 for exactly WR_HOLD cycles (N+1..N+WR_HOLD); waddr/wdata stay stable over that window.
  - char_ready=0 throughout.
  - On the last hold cycle the cursor advances: col+1. If col was COLS-1, col=0 and the row advances.
  - Row advance from ROWS-1 wraps to 0 and enters CLR_LINE; otherwise the state returns to IDLE.
  - A BS write does not advance the cursor.
- CLR_LINE
  - Writes 0x20 to cells (cur_row, 0..COLS-1) in ascending order, each with WR_HOLD-cycle strobes back-to-back (selRW stays high continuously; waddr changes every WR_HOLD cycles).
  - Then returns to IDLE with the cursor at (cur_row, 0).
- CLR_ALL
  - Same as CLR_LINE but over all ROWS*COLS cells in row-major order.
  - Ends with the cursor at (0,0), then IDLE.
- Timing:
  - Duration: CLR_LINE takes COLS*WR_HOLD cycles; CLR_ALL takes ROWS*COLS*WR_HOLD cycles.
  - Latency: accepted printable char → first selRW cycle is 1 cycle; next char_ready assertion is WR_HOLD+1 cycles after acceptance.
- Simultaneous events: char_valid while busy is ignored (not consumed); the source must hold char_valid until it sees char_ready.
- Arithmetic:
  - The cursor counters never hold values ≥COLS or ≥ROWS.
  - waddr is computed unsigned, 32-bit wrap.
- All outputs are registered (no combinational path from char_valid to selRW).

Test Plan:
- CLEAR_ON_RESET=0, WR_HOLD=2: release reset, send 'A'(0x41) → selRW high 2 cycles, waddr=0, wdata=0x41; cursor (0,1); char_ready back high 3 cycles after accept.
- Send 80 printable chars, then 'B' → 'B' written at waddr=128 (row 1, col 0); cursor (1,1).
- Cursor at (31,5), send 0x0A → 80 writes of 0x20 at waddr 0..79, selRW continuous for 160 cycles, busy=1 throughout; final cursor (0,0).
- Cursor at (0,0), send 0x08 → no strobe, cursor unchanged. At (3,7), send 0x08 → write 0x20 at waddr 3*128+6=390; cursor (3,6).
- Send 0x0C from (10,10) → 2560 writes of 0x20 covering waddr 0..79, 128..207, …, 3968..4047; char_ready low 5120 cycles; cursor (0,0). Send 0x07 → consumed, no write.
- Assert rst mid-CLR_ALL → outputs go to 0 asynchronously. With CLEAR_ON_RESET=1, release restarts a full clear from waddr=0 before char_ready rises.
